// File: rtl/axi2per_res_pkg.sv
// axi2per_res_pkg: shared types and constants for the axi2per response generator.
//   meta_t      - per-beat metadata view of the metadata FIFO head
//   res_state_e - output-stage state encoding
//   RESP_*      - AXI response codes
// ID/user fields in meta_t are sized to upper bounds; the top only stores the
// configured widths in its FIFO and zero-extends into this view.
package axi2per_res_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned META_ID_W   = 8;
  localparam int unsigned META_USER_W = 16;

  typedef struct packed {
    logic                   we;
    logic                   last;
    logic [META_ID_W-1:0]   id;
    logic [META_USER_W-1:0] user;
    logic                   lane;
  } meta_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND_R = 2'd1,
    ST_SEND_B = 2'd2
  } res_state_e;

endpackage

// File: rtl/axi2per_res_fifo.sv
// axi2per_res_fifo: synchronous FIFO with registered occupancy.
//   clk_i/rst_ni    - clock, asynchronous active-low reset
//   push_i/data_i   - write side; accepted when not full, or full with a pop
//   pop_i/data_o    - read side; data_o shows the head, pop ignored when empty
//   full_o/empty_o  - derived from the registered count
//   count_o         - number of stored entries
module axi2per_res_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  import axi2per_res_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_en, pop_en;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    pop_en  = pop_i && !empty_o;
    push_en = push_i && (!full_o || pop_en);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_en) wptr_d = wptr_q + PTR_W'(1);
    if (pop_en)  rptr_d = rptr_q + PTR_W'(1);
    if (push_en && !pop_en)      count_d = count_q + CNT_W'(1);
    else if (pop_en && !push_en) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_en) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/axi2per_res_gen.sv
// axi2per_res_gen: turns in-order 32-bit peripheral responses into AXI R/B beats.
//   trans_*            - request channel announces each issued peripheral beat
//   res_space_o        - metadata slot free; request channel may issue
//   per_master_r_*     - peripheral responses (no backpressure)
//   axi_slave_r_*/b_*  - AXI read-data and write-response channels
// Optional macro AXI2PER_RES_LANE_SEL_EN: R data placed in lane add[2] with the
// other lane zero; otherwise the word is replicated and add[2] is not stored.
// AXI_ID_WIDTH <= 8 and AXI_USER_WIDTH <= 16 (bounds of the package meta view).
module axi2per_res_gen #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 3,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      per_master_r_valid_i,
  input  logic                      per_master_r_opc_i,
  input  logic [31:0]               per_master_r_rdata_i,
  input  logic                      trans_req_i,
  input  logic                      trans_we_i,
  input  logic                      trans_last_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [AXI_USER_WIDTH-1:0] trans_user_i,
  input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
  output logic                      res_space_o,
  output logic                      axi_slave_r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o,
  output logic [1:0]                axi_slave_r_resp_o,
  output logic                      axi_slave_r_last_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_r_user_o,
  input  logic                      axi_slave_r_ready_i,
  output logic                      axi_slave_b_valid_o,
  output logic [1:0]                axi_slave_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_b_user_o,
  input  logic                      axi_slave_b_ready_i
);
  import axi2per_res_pkg::*;

`ifdef AXI2PER_RES_LANE_SEL_EN
  localparam int unsigned LANE_W = 1;
`else
  localparam int unsigned LANE_W = 0;
`endif
  localparam int unsigned META_W = 2 + AXI_ID_WIDTH + AXI_USER_WIDTH + LANE_W;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [META_W-1:0] meta_wdata, meta_rdata;
  logic              meta_push, meta_full, meta_empty;
  logic [CNT_W-1:0]  meta_count;
  logic [32:0]       resp_wdata, resp_rdata;
  logic              resp_push, resp_full, resp_empty;
  logic [CNT_W-1:0]  resp_count;
  logic              pair_pop, heads_valid, slot_free;
  meta_t             head;

  res_state_e                state_q, state_d;
  logic                      err_q, err_d;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]                r_resp_q, r_resp_d, b_resp_q, b_resp_d;
  logic                      r_last_q, r_last_d;
  logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d, b_id_q, b_id_d;
  logic [AXI_USER_WIDTH-1:0] r_user_q, r_user_d, b_user_q, b_user_d;

  // Only the registered count gates issue: a slot freed this cycle is visible next cycle.
  assign res_space_o = (meta_count < CNT_W'(FIFO_DEPTH));
  assign meta_push   = trans_req_i && res_space_o;
  assign resp_push   = per_master_r_valid_i && !meta_empty;
  assign resp_wdata  = {per_master_r_opc_i, per_master_r_rdata_i};

  always_comb begin
`ifdef AXI2PER_RES_LANE_SEL_EN
    meta_wdata = {trans_we_i, trans_last_i, trans_id_i, trans_user_i, trans_add_i[2]};
`else
    meta_wdata = {trans_we_i, trans_last_i, trans_id_i, trans_user_i};
`endif
  end

  axi2per_res_fifo #(.DATA_WIDTH(META_W), .DEPTH(FIFO_DEPTH)) u_meta_fifo (
    .clk_i, .rst_ni, .push_i(meta_push), .data_i(meta_wdata), .pop_i(pair_pop),
    .data_o(meta_rdata), .full_o(meta_full), .empty_o(meta_empty), .count_o(meta_count)
  );

  axi2per_res_fifo #(.DATA_WIDTH(33), .DEPTH(FIFO_DEPTH)) u_resp_fifo (
    .clk_i, .rst_ni, .push_i(resp_push), .data_i(resp_wdata), .pop_i(pair_pop),
    .data_o(resp_rdata), .full_o(resp_full), .empty_o(resp_empty), .count_o(resp_count)
  );

  always_comb begin
    head      = '0;
    head.we   = meta_rdata[META_W-1];
    head.last = meta_rdata[META_W-2];
    head.id   = META_ID_W'(meta_rdata[LANE_W+AXI_USER_WIDTH +: AXI_ID_WIDTH]);
    head.user = META_USER_W'(meta_rdata[LANE_W +: AXI_USER_WIDTH]);
`ifdef AXI2PER_RES_LANE_SEL_EN
    head.lane = meta_rdata[0];
`endif
  end

  // Next state: the output register can be (re)loaded whenever it is empty or
  // its beat is being accepted, which gives back-to-back beats.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    r_data_d = r_data_q;
    r_resp_d = r_resp_q;
    r_last_d = r_last_q;
    r_id_d   = r_id_q;
    r_user_d = r_user_q;
    b_resp_d = b_resp_q;
    b_id_d   = b_id_q;
    b_user_d = b_user_q;
    heads_valid = !meta_empty && !resp_empty;
    case (state_q)
      ST_SEND_R: slot_free = axi_slave_r_ready_i;
      ST_SEND_B: slot_free = axi_slave_b_ready_i;
      default:   slot_free = 1'b1;
    endcase
    pair_pop = slot_free && heads_valid;
    if (slot_free) state_d = ST_IDLE;
    if (pair_pop) begin
      if (!head.we) begin
        state_d = ST_SEND_R;
`ifdef AXI2PER_RES_LANE_SEL_EN
        r_data_d = head.lane ? {resp_rdata[31:0], 32'h0} : {32'h0, resp_rdata[31:0]};
`else
        r_data_d = {resp_rdata[31:0], resp_rdata[31:0]};
`endif
        r_resp_d = resp_rdata[32] ? RESP_SLVERR : RESP_OKAY;
        r_last_d = head.last;
        r_id_d   = head.id[AXI_ID_WIDTH-1:0];
        r_user_d = head.user[AXI_USER_WIDTH-1:0];
      end else if (!head.last) begin
        err_d = err_q | resp_rdata[32];
      end else begin
        state_d  = ST_SEND_B;
        b_resp_d = (err_q | resp_rdata[32]) ? RESP_SLVERR : RESP_OKAY;
        b_id_d   = head.id[AXI_ID_WIDTH-1:0];
        b_user_d = head.user[AXI_USER_WIDTH-1:0];
        err_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      err_q    <= 1'b0;
      r_data_q <= '0;
      r_resp_q <= '0;
      r_last_q <= 1'b0;
      r_id_q   <= '0;
      r_user_q <= '0;
      b_resp_q <= '0;
      b_id_q   <= '0;
      b_user_q <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      r_data_q <= r_data_d;
      r_resp_q <= r_resp_d;
      r_last_q <= r_last_d;
      r_id_q   <= r_id_d;
      r_user_q <= r_user_d;
      b_resp_q <= b_resp_d;
      b_id_q   <= b_id_d;
      b_user_q <= b_user_d;
    end
  end

  always_comb begin
    axi_slave_r_valid_o = (state_q == ST_SEND_R);
    axi_slave_b_valid_o = (state_q == ST_SEND_B);
  end

  assign axi_slave_r_data_o = r_data_q;
  assign axi_slave_r_resp_o = r_resp_q;
  assign axi_slave_r_last_o = r_last_q;
  assign axi_slave_r_id_o   = r_id_q;
  assign axi_slave_r_user_o = r_user_q;
  assign axi_slave_b_resp_o = b_resp_q;
  assign axi_slave_b_id_o   = b_id_q;
  assign axi_slave_b_user_o = b_user_q;

  logic unused_sigs;
  assign unused_sigs = ^{trans_add_i, head, meta_full, resp_full, resp_count};

`ifndef SYNTHESIS
  a_meta_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    trans_req_i |-> res_space_o);
  a_resp_has_meta: assert property (@(posedge clk_i) disable iff (!rst_ni)
    per_master_r_valid_i |-> !meta_empty);
`endif

endmodule
